// File: rtl/coax_defs.sv
// Shared coax definitions: word width and buffer FSM state encodings,
// kept separate so the receive-side buffering can reuse them.
package coax_defs;

  localparam int COAX_WORD_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } coax_buf_state_t;

endpackage

// File: rtl/coax_fifo.sv
// First-word-fall-through FIFO: register array, wrapping pointers, occupancy
// count and full/empty flags derived from the registered count.
module coax_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; its contents are don't-care until
  // written, and leaving it out of reset lets it map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/coax_tx_buffer.sv
// Frame buffer in front of coax_tx: queues host words and drains them through
// the strobe/ready handshake so a frame leaves back-to-back.
module coax_tx_buffer
  import coax_defs::*;
#(
  parameter int DEPTH           = 16,
  parameter int ADDR_WIDTH      = 4,
  parameter int START_THRESHOLD = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [COAX_WORD_WIDTH-1:0] wr_data,
  input  logic                       wr_strobe,
  input  logic                       commit,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [ADDR_WIDTH:0]        count,
  output logic                       overflow,
  output logic                       underrun,
  output logic                       busy,
  output logic [COAX_WORD_WIDTH-1:0] tx_data,
  output logic                       tx_strobe,
  input  logic                       tx_ready
);

  coax_buf_state_t     state, state_next;
  logic                committed, committed_next;
  logic                underrun_set;
  logic                push, pop;
  logic [ADDR_WIDTH:0] count_next;

  assign push = wr_strobe && !full && !flush;
  assign pop  = tx_strobe && tx_ready && !flush;

  coax_fifo #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (COAX_WORD_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (tx_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Occupancy after this edge; the FSM decides on it so a frame never stalls.
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (!push && pop) count_next = count - 1'b1;
  end

  // Flush takes the same path as reset so the next cycle matches reset state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      committed <= 1'b0;
      overflow  <= 1'b0;
      underrun  <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      committed <= 1'b0;
      overflow  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_next;
      committed <= committed_next;
      if (wr_strobe && full) overflow <= 1'b1;
      if (underrun_set)      underrun <= 1'b1;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    committed_next = committed;
    underrun_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (push) begin
          state_next     = ST_FILL;
          committed_next = commit;
        end
      end
      ST_FILL: begin
        if (commit) committed_next = 1'b1;
        if (count_next >= (ADDR_WIDTH+1)'(START_THRESHOLD) || commit || committed)
          state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (commit) committed_next = 1'b1;
        if (count_next == '0) begin
          // Emptied without a commit: coax_tx will close the frame early.
          state_next     = ST_IDLE;
          committed_next = 1'b0;
          underrun_set   = !(committed || commit);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    tx_strobe = (state == ST_DRAIN) && !empty;
  end

endmodule
